// File: rtl/program_loader_if.sv
// Byte-stream handshake between a serial receiver and the program loader.
// A byte transfers on a rising edge where rx_valid and rx_ready are both high.
interface program_loader_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (output rx_valid, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/program_loader.sv
// Boot loader that assembles little-endian 32-bit words from a framed byte stream,
// writes them to instruction RAM, and releases the CPU once the XOR checksum matches.
module program_loader #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  program_loader_if.slave       rx,
  output logic                  instruction_write,
  output logic [31:0]           instruction_in,
  output logic                  run_enable,
  output logic                  load_error,
  output logic [ADDR_WIDTH-2:0] words_loaded
);

  localparam int MAX_WORDS = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CSUM,
    RUN,
    ERROR
  } state_t;

  state_t      state;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic [23:0] word_buf;
  logic [15:0] header;
  logic        accept;
  logic        last_word;

  assign header    = {rx.rx_data, n_lo};
  assign last_word = (int'(words_loaded) + 1) == int'(n_words);

  // Ready is decoded from state only, so the sender never sees a cycle of lag.
  assign rx.rx_ready = !rst && (state inside {HDR_LO, HDR_HI, DATA, CSUM});
  assign accept      = rx.rx_valid && rx.rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= HDR_LO;
      n_lo              <= '0;
      n_words           <= '0;
      byte_idx          <= '0;
      csum              <= '0;
      word_buf          <= '0;
      instruction_write <= 1'b0;
      instruction_in    <= '0;
      run_enable        <= 1'b0;
      load_error        <= 1'b0;
      words_loaded      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side sees
      // the pre-edge value regardless of statement order.
      instruction_write <= 1'b0;
      if (accept) begin
        unique case (state)
          HDR_LO: begin
            n_lo  <= rx.rx_data;
            state <= HDR_HI;
          end
          HDR_HI: begin
            n_words  <= header;
            byte_idx <= '0;
            csum     <= '0;
            if (header == 16'd0 || int'(header) > MAX_WORDS) begin
              state      <= ERROR;
              load_error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            csum     <= csum ^ rx.rx_data;
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: word_buf[7:0]   <= rx.rx_data;
              2'd1: word_buf[15:8]  <= rx.rx_data;
              2'd2: word_buf[23:16] <= rx.rx_data;
              2'd3: begin
                instruction_in    <= {rx.rx_data, word_buf};
                instruction_write <= 1'b1;
                if (words_loaded != '1) words_loaded <= words_loaded + 1'b1;
                if (last_word) state <= CSUM;
              end
            endcase
          end
          CSUM: begin
            if (rx.rx_data == csum) begin
              state      <= RUN;
              run_enable <= 1'b1;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a frame-level reference model predicts the
// write words and final status, and a monitor checks every write strobe.
module tb_program_loader;
  localparam int ADDR_WIDTH = 16;
  localparam int MAX_WORDS  = 2 ** (ADDR_WIDTH - 2);

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] word;
    int          count;
  } wr_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  instruction_write;
  logic [31:0]           instruction_in;
  logic                  run_enable;
  logic                  load_error;
  logic [ADDR_WIDTH-2:0] words_loaded;

  program_loader_if rx ();

  program_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .rx                (rx.slave),
    .instruction_write (instruction_write),
    .instruction_in    (instruction_in),
    .run_enable        (run_enable),
    .load_error        (load_error),
    .words_loaded      (words_loaded)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cycle  = 0;
  wr_t    exp_q[$];
  longint strobe_t[$];

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (rst !== 1'b1 && instruction_write === 1'b1) begin
      strobe_t.push_back(cycle);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {32'd0, instruction_in}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_word", {32'd0, instruction_in}, {32'd0, e.word});
        check("write_count", 64'(words_loaded), 64'(e.count));
      end
    end
  end

  // Reference model: parses a frame as a whole and predicts writes and outcome.
  function automatic void model(input bq_t f, output int term_idx, output bit term_ok,
                                output int nw);
    int         n;
    logic [7:0] x;
    wr_t        e;
    term_idx = -1;
    term_ok  = 1'b0;
    nw       = 0;
    if (f.size() < 2) return;
    n = int'({f[1], f[0]});
    if (n == 0 || n > MAX_WORDS) begin
      term_idx = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (2 + 4 * i + 3 >= f.size()) break;
      e.word  = {f[2+4*i+3], f[2+4*i+2], f[2+4*i+1], f[2+4*i]};
      e.count = i + 1;
      exp_q.push_back(e);
      nw++;
    end
    if (f.size() <= 2 + 4 * n) return;
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) x ^= f[2+i];
    term_idx = 2 + 4 * n;
    term_ok  = (f[term_idx] == x);
  endfunction

  // Drives one byte after `gap` idle cycles; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    rx.rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx.rx_valid = 1'b1;
    rx.rx_data  = b;
    waited = 0;
    while (rx.rx_ready !== 1'b1 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 50) begin
      check("ready_timeout", 64'(rx.rx_ready), 64'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    rx.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    rx.rx_valid = 1'b0;
    rx.rx_data  = 8'h00;
    @(posedge clk);
    #1;
    check("rst_write", 64'(instruction_write), 64'd0);
    check("rst_word", 64'(instruction_in), 64'd0);
    check("rst_run", 64'(run_enable), 64'd0);
    check("rst_err", 64'(load_error), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    check("rst_ready", 64'(rx.rx_ready), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    #1;
    check("rst_ready_after", 64'(rx.rx_ready), 64'd1);
  endtask

  task automatic run_frame(input string tag, input bq_t f, input int max_gap);
    int term_idx;
    bit term_ok;
    int nw;
    model(f, term_idx, term_ok, nw);
    for (int i = 0; i < f.size(); i++) begin
      if (term_idx >= 0 && i > term_idx) break;
      send_byte(f[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
      if (i == term_idx) begin
        check({tag, "_run"}, 64'(run_enable), 64'(term_ok));
        check({tag, "_err"}, 64'(load_error), 64'(!term_ok));
        check({tag, "_ready"}, 64'(rx.rx_ready), 64'd0);
      end
    end
    if (term_idx >= 0) begin
      // Bytes offered after the frame ends must be ignored entirely.
      for (int k = 0; k < 4; k++) begin
        rx.rx_valid = 1'b1;
        rx.rx_data  = 8'($urandom);
        @(posedge clk);
        #1;
      end
      rx.rx_valid = 1'b0;
      check({tag, "_run_hold"}, 64'(run_enable), 64'(term_ok));
      check({tag, "_err_hold"}, 64'(load_error), 64'(!term_ok));
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'(nw));
  endtask

  function automatic bq_t make_frame(input int n, input bit corrupt);
    bq_t        f;
    logic [7:0] x;
    logic [7:0] b;
    logic [15:0] nn;
    nn = 16'(n);
    f.push_back(nn[7:0]);
    f.push_back(nn[15:8]);
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      x ^= b;
      f.push_back(b);
    end
    f.push_back(corrupt ? (x ^ 8'h01) : x);
    return f;
  endfunction

  initial begin
    bq_t nominal;
    bq_t f;
    rst         = 1'b1;
    rx.rx_valid = 1'b0;
    rx.rx_data  = 8'h00;
    nominal = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};

    do_reset();
    run_frame("nominal", nominal, 0);

    do_reset();
    f = nominal;
    f[10] = 8'h91;
    run_frame("bad_csum", f, 0);

    do_reset();
    run_frame("hdr_zero", '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, 0);

    do_reset();
    run_frame("hdr_big", '{8'h01, 8'h40, 8'h11, 8'h22, 8'h33, 8'h44}, 0);

    do_reset();
    run_frame("gaps", nominal, 5);

    do_reset();
    run_frame("partial", '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93}, 0);
    do_reset();
    run_frame("after_rst", '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22}, 0);

    do_reset();
    strobe_t.delete();
    run_frame("n4", make_frame(4, 1'b0), 0);
    check("n4_strobes", 64'(strobe_t.size()), 64'd4);
    if (strobe_t.size() == 4) begin
      for (int i = 1; i < 4; i++) check("n4_spacing", 64'(strobe_t[i] - strobe_t[i-1]), 64'd4);
    end

    for (int t = 0; t < 6; t++) begin
      do_reset();
      run_frame("random", make_frame(int'($urandom_range(1, 6)), t == 3), 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
